mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/arb_pkg.sv | 14 +
 rtl/hold_timer.sv | 37 +++
 rtl/mem_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the two-port L1-to-memory bus arbiter.
package arb_pkg;

    localparam int N_REQ  = 2;
    localparam int ADDR_W = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        TURN   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/hold_timer.sv
// Saturating grant-hold counter; tc_o flags the edge at which the count is (or stays) at MAX_HOLD.
module hold_timer #(
    parameter int MAX_HOLD = 16,
    localparam int CNT_W   = $clog2(MAX_HOLD + 1)
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_HOLD);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != MAX_C)) begin
            count_d = count_q + 1'b1;
        end
    end

    assign tc_o = enable_i & ~clear_i & (count_d == MAX_C);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter granting one of two L1 controllers the memory bus, with a turnaround cycle.
//   state  | meaning
//   IDLE   | no owner, arbitrate on sampled req
//   GRANT0 | controller 0 owns the bus
//   GRANT1 | controller 1 owns the bus
//   TURN   | one dead cycle after release, then arbitrate again
module mem_bus_arbiter
    import arb_pkg::*;
#(
    parameter int n        = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ-1:0]  done,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              load0,
    input  logic              load1,
    input  logic              store0,
    input  logic              store1,
    input  logic [n-1:0]      wdata0,
    input  logic [n-1:0]      wdata1,
    output logic [N_REQ-1:0]  grant,
    output logic              bus_owner,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_load,
    output logic              bus_store,
    output logic [n-1:0]      bus_wdata,
    output logic [N_REQ-1:0]  stall,
    output logic              timeout
);

    arb_state_t       state_q, state_d;
    logic             last_owner_q, last_owner_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             timeout_q, timeout_d;
    logic             in_grant, next_in_grant, cur_owner, other_pending, hold_tc;

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE, TURN: begin
                if (req[0] && req[1]) begin
                    state_d = last_owner_q ? GRANT0 : GRANT1;
                end else if (req[0]) begin
                    state_d = GRANT0;
                end else if (req[1]) begin
                    state_d = GRANT1;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT0: begin
                if (done[0] || !req[0]) begin
                    state_d      = TURN;
                    last_owner_d = 1'b0;
                end
            end
            GRANT1: begin
                if (done[1] || !req[1]) begin
                    state_d      = TURN;
                    last_owner_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_grant      = (state_q == GRANT0) || (state_q == GRANT1);
    assign next_in_grant = (state_d == GRANT0) || (state_d == GRANT1);
    assign cur_owner     = (state_q == GRANT1);
    assign other_pending = cur_owner ? req[0] : req[1];

    // Grant is registered from the next state so it lines up with state_q without a req->grant path.
    assign grant_d   = {state_d == GRANT1, state_d == GRANT0};
    assign timeout_d = timeout_q | (hold_tc & other_pending);

    hold_timer #(
        .MAX_HOLD(MAX_HOLD)
    ) u_hold_timer (
        .clk_i   (clk),
        .reset_i (reset),
        .clear_i (~in_grant & next_in_grant),
        .enable_i(in_grant),
        .tc_o    (hold_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            grant_q      <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            grant_q      <= grant_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        bus_addr  = '0;
        bus_load  = 1'b0;
        bus_store = 1'b0;
        bus_wdata = '0;
        case (grant_q)
            2'b01: begin
                bus_addr  = addr0;
                bus_load  = load0;
                bus_store = store0;
                bus_wdata = wdata0;
            end
            2'b10: begin
                bus_addr  = addr1;
                bus_load  = load1;
                bus_store = store1;
                bus_wdata = wdata1;
            end
            default: ;
        endcase
    end

    assign grant     = grant_q;
    assign bus_owner = in_grant ? cur_owner : last_owner_q;
    assign stall     = (req & ~grant_q) | (grant_q & ~done);
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a bus-ownership model checked every cycle, plus literal pins.
module tb_mem_bus_arbiter;

    localparam int NW  = 32;
    localparam int MH  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req, done;
    logic [14:0] addr0, addr1;
    logic        load0, load1, store0, store1;
    logic [31:0] wdata0, wdata1;
    logic [1:0]  grant;
    logic        bus_owner;
    logic [14:0] bus_addr;
    logic        bus_load, bus_store;
    logic [31:0] bus_wdata;
    logic [1:0]  stall;
    logic        timeout;

    int tests  = 0;
    int failed = 0;
    bit chk_en = 0;

    // model: owner is -1 when nobody holds the bus
    int m_owner, m_last, m_hold;
    bit m_to;

    mem_bus_arbiter #(.n(NW), .MAX_HOLD(MH)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .addr0(addr0), .addr1(addr1), .load0(load0), .load1(load1),
        .store0(store0), .store1(store1), .wdata0(wdata0), .wdata1(wdata1),
        .grant(grant), .bus_owner(bus_owner), .bus_addr(bus_addr),
        .bus_load(bus_load), .bus_store(bus_store), .bus_wdata(bus_wdata),
        .stall(stall), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_owner = -1;
            m_last  = 1;
            m_hold  = 0;
            m_to    = 0;
        end else if (m_owner >= 0) begin
            m_hold = (m_hold + 1 > MH) ? MH : m_hold + 1;
            if (m_hold == MH && req[1 - m_owner]) m_to = 1;
            if (done[m_owner] || !req[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end else if (req != 2'b00) begin
            // Released bus must idle for one cycle: only arbitrate if we did not just release.
            m_owner = (req == 2'b11) ? 1 - m_last : (req[0] ? 0 : 1);
            m_hold  = 0;
        end
    end

    // Turnaround tracking: the release edge itself leaves owner=-1, and arbitration
    // happens at the following edge, so the model above already gives one dead cycle.

    always @(negedge clk) begin
        if (chk_en) begin
            logic [1:0]  e_grant;
            logic [14:0] e_addr;
            logic        e_ld, e_st;
            logic [31:0] e_wd;
            e_grant = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
            e_addr  = (m_owner == 0) ? addr0  : (m_owner == 1) ? addr1  : 15'd0;
            e_ld    = (m_owner == 0) ? load0  : (m_owner == 1) ? load1  : 1'b0;
            e_st    = (m_owner == 0) ? store0 : (m_owner == 1) ? store1 : 1'b0;
            e_wd    = (m_owner == 0) ? wdata0 : (m_owner == 1) ? wdata1 : 32'd0;
            chk("grant", grant, e_grant);
            chk("bus_owner", bus_owner, (m_owner >= 0) ? m_owner[0] : m_last[0]);
            chk("bus_addr", bus_addr, e_addr);
            chk("bus_load", bus_load, e_ld);
            chk("bus_store", bus_store, e_st);
            chk("bus_wdata", bus_wdata, e_wd);
            chk("stall", stall, (req & ~e_grant) | (e_grant & ~done));
            chk("timeout", timeout, m_to);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b1;
        req    = 2'b00;
        done   = 2'b00;
        addr0  = 15'h1A4;  addr1  = 15'h7FFF;
        load0  = 1'b0;     load1  = 1'b1;
        store0 = 1'b1;     store1 = 1'b0;
        wdata0 = 32'hDEADBEEF;
        wdata1 = 32'h12345678;
        cyc();
        chk_en = 1;
        cyc();
        chk("rst_grant", grant, 2'b00);
        chk("rst_owner", bus_owner, 1'b1);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_bus_addr", bus_addr, 15'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);

        // Both request after reset: core 0 first, then core 1 after TURN
        reset = 1'b0;
        req   = 2'b11;
        cyc();
        chk("s1_grant_c2", grant, 2'b01);
        chk("s1_stall", stall, 2'b11);
        cyc();
        done = 2'b01;
        #1 chk("s1_stall_done", stall, 2'b10);
        cyc();
        done = 2'b00;
        chk("s1_turn", grant, 2'b00);
        cyc();
        chk("s1_grant1", grant, 2'b10);
        chk("s1_owner1", bus_owner, 1'b1);
        req = 2'b00;
        cyc();
        cyc();

        // Core 0 alone with done every third grant cycle
        req = 2'b01;
        cyc();
        for (int r = 0; r < 2; r++) begin
            for (int k = 1; k <= 3; k++) begin
                chk("s2_grant", grant, 2'b01);
                chk("s2_owner", bus_owner, 1'b0);
                if (k == 3) done = 2'b01;
                cyc();
            end
            done = 2'b00;
            chk("s2_turn", grant, 2'b00);
            chk("s2_owner_turn", bus_owner, 1'b0);
            cyc();
        end
        req = 2'b00;
        cyc();
        cyc();

        // Bus mux contents during GRANT0 and zeroed in TURN
        req = 2'b01;
        cyc();
        chk("s3_addr", bus_addr, 15'h1A4);
        chk("s3_store", bus_store, 1'b1);
        chk("s3_load", bus_load, 1'b0);
        chk("s3_wdata", bus_wdata, 32'hDEADBEEF);
        done = 2'b01;
        cyc();
        done = 2'b00;
        #1;
        chk("s3_turn_addr", bus_addr, 15'd0);
        chk("s3_turn_store", bus_store, 1'b0);
        chk("s3_turn_wdata", bus_wdata, 32'd0);

        // Non-owner done is ignored; dropping req releases the bus
        cyc();
        chk("s4_grant", grant, 2'b01);
        done = 2'b10;
        cyc();
        done = 2'b00;
        chk("s4_ignore_done1", grant, 2'b01);
        req = 2'b00;
        cyc();
        chk("s4_drop_turn", grant, 2'b00);
        cyc();

        // Hold timeout with core 1 pending; grant is never pre-empted
        req = 2'b01;
        cyc();
        req = 2'b11;
        for (int k = 0; k < MH - 1; k++) cyc();
        chk("s5_no_to_15", timeout, 1'b0);
        cyc();
        chk("s5_to_16", timeout, 1'b1);
        chk("s5_grant_kept", grant, 2'b01);
        cyc();
        chk("s5_grant_sat", grant, 2'b01);
        done = 2'b01;
        cyc();
        done = 2'b00;
        chk("s5_turn", grant, 2'b00);
        cyc();
        chk("s5_grant1", grant, 2'b10);
        chk("s5_to_sticky", timeout, 1'b1);

        // Reset during GRANT1 with both requests held
        reset = 1'b1;
        cyc();
        chk("s6_rst_grant", grant, 2'b00);
        chk("s6_rst_to", timeout, 1'b0);
        chk("s6_rst_owner", bus_owner, 1'b1);
        reset = 1'b0;
        cyc();
        chk("s6_regrant0", grant, 2'b01);
        req = 2'b00;
        cyc();
        cyc();

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
